// File: rtl/pose_record_playback.sv
// pose_record_playback
//   Records accelerometer poses (x,y,z) into a small pose memory at a fixed
//   sample rate. It plays them back in order, holding each pose for a fixed
//   number of cycles, and can loop back to the first entry.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     enable              1 = run, 0 = freeze timers, pointers and writes
//     btn_rec             pulse: start/stop recording
//     btn_play            pulse: start/stop playback
//     btn_clear           pulse: empty the pose memory (IDLE only)
//     loop                1 = playback wraps to entry 0 after the last entry
//     accel_x/y/z         live accelerometer axes
//     mem_x/y/z           pose currently played back (holds after playback)
//     mem_valid           1 while mem_x/y/z carries a playback pose
//     count, full         stored pose count (0..DEPTH), count == DEPTH
//     state               0 IDLE, 1 REC, 2 PLAY (also serves as FSM debug view)
//
//   Handshake note: the buttons are single-cycle strobes with no ready/ack.
//   A strobe is consumed on the edge where it is high. It is ignored when the
//   current state gives it no meaning.
module pose_record_playback #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int ADDR_W      = 4,
   parameter int SAMPLE_DIV  = 5_000_000,
   parameter int STEP_CYCLES = 50_000_000,
   parameter int NEUTRAL     = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              btn_rec,
   input  logic              btn_play,
   input  logic              btn_clear,
   input  logic              loop,
   input  logic [DATA_W-1:0] accel_x,
   input  logic [DATA_W-1:0] accel_y,
   input  logic [DATA_W-1:0] accel_z,
   output logic [DATA_W-1:0] mem_x,
   output logic [DATA_W-1:0] mem_y,
   output logic [DATA_W-1:0] mem_z,
   output logic              mem_valid,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic [1:0]        state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REC  = 2'd1;
   localparam logic [1:0] S_PLAY = 2'd2;

   localparam int SAMPLE_W = (SAMPLE_DIV  > 2) ? $clog2(SAMPLE_DIV)  : 1;
   localparam int STEP_W   = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_DIV - 1);
   localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_CYCLES - 1);
   localparam logic [ADDR_W:0]     DEPTH_C     = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]     ONE_C       = (ADDR_W+1)'(1);
   localparam logic [DATA_W-1:0]   NEUTRAL_C   = DATA_W'(NEUTRAL);

   logic [DATA_W-1:0]   mem_x_arr [DEPTH];
   logic [DATA_W-1:0]   mem_y_arr [DEPTH];
   logic [DATA_W-1:0]   mem_z_arr [DEPTH];

   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [SAMPLE_W-1:0] sample_tmr;
   logic [STEP_W-1:0]   step_tmr;
   logic [ADDR_W:0]     last_idx;
   logic                wr_en;

   assign full     = (count == DEPTH_C);
   assign last_idx = count - ONE_C;

   // A stop request on the write cycle wins, so the sample is not stored.
   assign wr_en = (state == S_REC) && enable && !btn_rec && (sample_tmr == SAMPLE_LAST);

   // Pose memory is deliberately not reset; count alone marks entries valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_x_arr[wr_ptr] <= accel_x;
         mem_y_arr[wr_ptr] <= accel_y;
         mem_z_arr[wr_ptr] <= accel_z;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         sample_tmr <= '0;
         step_tmr   <= '0;
         mem_x      <= NEUTRAL_C;
         mem_y      <= NEUTRAL_C;
         mem_z      <= NEUTRAL_C;
         mem_valid  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (btn_clear) begin
                  count <= '0;
               end else if (btn_rec && !full) begin
                  state      <= S_REC;
                  sample_tmr <= '0;
                  wr_ptr     <= count[ADDR_W-1:0];
               end else if (btn_play && (count != '0)) begin
                  state    <= S_PLAY;
                  rd_ptr   <= '0;
                  step_tmr <= '0;
               end
            end
            S_REC: begin
               if (btn_rec) begin
                  state <= S_IDLE;
               end else if (enable) begin
                  if (sample_tmr == SAMPLE_LAST) begin
                     sample_tmr <= '0;
                     wr_ptr     <= wr_ptr + ADDR_W'(1);
                     count      <= count + ONE_C;
                     // The write that fills the memory also ends recording.
                     if (count == DEPTH_C - ONE_C) state <= S_IDLE;
                  end else begin
                     sample_tmr <= sample_tmr + SAMPLE_W'(1);
                  end
               end
            end
            S_PLAY: begin
               if (btn_play) begin
                  state     <= S_IDLE;
                  mem_valid <= 1'b0;
               end else if (enable) begin
                  // Registered read: outputs follow rd_ptr one cycle late.
                  mem_x     <= mem_x_arr[rd_ptr];
                  mem_y     <= mem_y_arr[rd_ptr];
                  mem_z     <= mem_z_arr[rd_ptr];
                  mem_valid <= 1'b1;
                  if (step_tmr == STEP_LAST) begin
                     step_tmr <= '0;
                     if ({1'b0, rd_ptr} != last_idx) begin
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                     end else if (loop) begin
                        rd_ptr <= '0;
                     end else begin
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                     end
                  end else begin
                     step_tmr <= step_tmr + STEP_W'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pose_record_playback.sv
module tb_pose_record_playback;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;
   localparam int SDIV   = 3;
   localparam int STEP   = 4;
   localparam int NEUT   = 50;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b1;
   logic              btn_rec = 1'b0, btn_play = 1'b0, btn_clear = 1'b0, loop = 1'b0;
   logic [DATA_W-1:0] accel_x = '0, accel_y = '0, accel_z = '0;
   logic [DATA_W-1:0] mem_x, mem_y, mem_z;
   logic              mem_valid, full;
   logic [ADDR_W:0]   count;
   logic [1:0]        state;

   int checks = 0;
   int errors = 0;

   pose_record_playback #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .SAMPLE_DIV(SDIV), .STEP_CYCLES(STEP), .NEUTRAL(NEUT)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .btn_rec(btn_rec), .btn_play(btn_play), .btn_clear(btn_clear), .loop(loop),
      .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
      .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z),
      .mem_valid(mem_valid), .count(count), .full(full), .state(state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic r, input logic p, input logic c);
      btn_rec = r; btn_play = p; btn_clear = c;
      tick();
      btn_rec = 1'b0; btn_play = 1'b0; btn_clear = 1'b0;
   endtask

   task automatic set_accel(input logic [7:0] v);
      accel_x = v; accel_y = v + 8'd1; accel_z = v + 8'd2;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rec, play, clr, en, lp;
      logic [7:0] ax;
      int         st, cnt, mx, vld;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic r, input logic p, input logic c, input logic e,
                      input logic l, input int ax, input int st, input int cnt,
                      input int mx, input int vld);
      vec_t v;
      v.rec = r; v.play = p; v.clr = c; v.en = e; v.lp = l; v.ax = 8'(ax);
      v.st = st; v.cnt = cnt; v.mx = mx; v.vld = vld;
      vecs.push_back(v);
   endtask

   // ---------------- reference model ----------------
   // Abstract view: a list of stored poses, a countdown of enabled cycles
   // to the next event, and the index of the pose being shown.
   int         m_state, m_wait, m_idx;
   logic [7:0] px[$], py[$], pz[$];
   logic [7:0] m_ox, m_oy, m_oz;
   bit         m_valid;

   task automatic model_reset();
      m_state = 0; m_wait = 0; m_idx = 0;
      px.delete(); py.delete(); pz.delete();
      m_ox = 8'(NEUT); m_oy = 8'(NEUT); m_oz = 8'(NEUT); m_valid = 0;
   endtask

   task automatic model_step(input bit r, input bit p, input bit c, input bit e,
                             input bit l, input logic [7:0] ax, input logic [7:0] ay,
                             input logic [7:0] az);
      case (m_state)
         0: begin
            if (c) begin
               px.delete(); py.delete(); pz.delete();
            end else if (r && px.size() < DEPTH) begin
               m_state = 1; m_wait = SDIV;
            end else if (p && px.size() > 0) begin
               m_state = 2; m_idx = 0; m_wait = STEP;
            end
         end
         1: begin
            if (r) m_state = 0;
            else if (e) begin
               m_wait--;
               if (m_wait == 0) begin
                  px.push_back(ax); py.push_back(ay); pz.push_back(az);
                  m_wait = SDIV;
                  if (px.size() == DEPTH) m_state = 0;
               end
            end
         end
         default: begin
            if (p) begin
               m_state = 0; m_valid = 0;
            end else if (e) begin
               m_ox = px[m_idx]; m_oy = py[m_idx]; m_oz = pz[m_idx]; m_valid = 1;
               m_wait--;
               if (m_wait == 0) begin
                  m_wait = STEP;
                  if (m_idx < px.size() - 1) m_idx++;
                  else if (l) m_idx = 0;
                  else begin
                     m_state = 0; m_valid = 0;
                  end
               end
            end
         end
      endcase
   endtask

   // ---------------- test ----------------
   int exp_loop[13];

   initial begin
      // Reset
      rst = 1'b1;
      tick(); tick();
      chk("rst_state", state, 0);
      chk("rst_count", count, 0);
      chk("rst_mem_x", mem_x, NEUT);
      chk("rst_mem_y", mem_y, NEUT);
      chk("rst_mem_z", mem_z, NEUT);
      chk("rst_valid", mem_valid, 0);
      chk("rst_full", full, 0);
      rst = 1'b0;
      tick();

      // Record two samples (10, 20), stop, then play once without loop.
      //   rec play clr en lp ax   st cnt mx vld
      add(1, 0, 0, 1, 0, 10,  1, 0, 50, 0);
      add(0, 0, 0, 1, 0, 10,  1, 0, 50, 0);
      add(0, 0, 0, 1, 0, 10,  1, 0, 50, 0);
      add(0, 0, 0, 1, 0, 10,  1, 1, 50, 0);
      add(0, 0, 0, 1, 0, 20,  1, 1, 50, 0);
      add(0, 0, 0, 1, 0, 20,  1, 1, 50, 0);
      add(0, 0, 0, 1, 0, 20,  1, 2, 50, 0);
      add(1, 0, 0, 1, 0, 30,  0, 2, 50, 0);
      add(0, 1, 0, 1, 0, 30,  2, 2, 50, 0);
      add(0, 0, 0, 1, 0, 30,  2, 2, 10, 1);
      add(0, 0, 0, 1, 0, 30,  2, 2, 10, 1);
      add(0, 0, 0, 1, 0, 30,  2, 2, 10, 1);
      add(0, 0, 0, 1, 0, 30,  2, 2, 10, 1);
      add(0, 0, 0, 1, 0, 30,  2, 2, 20, 1);
      add(0, 0, 0, 1, 0, 30,  2, 2, 20, 1);
      add(0, 0, 0, 1, 0, 30,  2, 2, 20, 1);
      add(0, 0, 0, 1, 0, 30,  0, 2, 20, 0);
      add(0, 0, 0, 1, 0, 30,  0, 2, 20, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         btn_rec = vecs[i].rec; btn_play = vecs[i].play; btn_clear = vecs[i].clr;
         enable = vecs[i].en; loop = vecs[i].lp; set_accel(vecs[i].ax);
         tick();
         btn_rec = 1'b0; btn_play = 1'b0; btn_clear = 1'b0;
         chk($sformatf("tbl%0d_state", i), state, vecs[i].st);
         chk($sformatf("tbl%0d_count", i), count, vecs[i].cnt);
         chk($sformatf("tbl%0d_mem_x", i), mem_x, vecs[i].mx);
         chk($sformatf("tbl%0d_valid", i), mem_valid, vecs[i].vld);
      end
      chk("tbl_mem_y", mem_y, 21);
      chk("tbl_mem_z", mem_z, 22);

      // Loop playback, enable stall, stop mid-step.
      exp_loop = '{10, 10, 10, 10, 20, 20, 20, 20, 10, 10, 10, 10, 20};
      loop = 1'b1;
      press(0, 1, 0);
      chk("loop_enter", state, 2);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("loop_t%0d", i), mem_x, exp_loop[i]);
      end
      enable = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stall_mem_x", mem_x, 10);
         chk("stall_state", state, 2);
      end
      enable = 1'b1;
      for (int i = 9; i < 13; i++) begin
         tick();
         chk($sformatf("loop_t%0d", i), mem_x, exp_loop[i]);
      end
      press(0, 1, 0);
      chk("stop_state", state, 0);
      chk("stop_valid", mem_valid, 0);
      chk("stop_hold", mem_x, 20);
      loop = 1'b0;

      // Clear and record in the same cycle: clear wins.
      press(1, 0, 1);
      chk("clr_rec_count", count, 0);
      chk("clr_rec_state", state, 0);

      // Play with an empty memory is ignored.
      press(0, 1, 0);
      chk("play_empty", state, 0);

      // Fill: writes at cycles 3,6,9,12, then back to IDLE with full set.
      set_accel(8'd77);
      press(1, 0, 0);
      chk("fill_enter", state, 1);
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk($sformatf("fill_c%0d", i), count, i / 3);
         chk($sformatf("fill_s%0d", i), state, (i < 12) ? 1 : 0);
      end
      chk("fill_full", full, 1);
      press(1, 0, 0);
      chk("rec_when_full", state, 0);

      // Async reset mid-PLAY.
      press(0, 1, 0);
      tick(); tick();
      chk("pre_rst_valid", mem_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", state, 0);
      chk("arst_count", count, 0);
      chk("arst_mem_x", mem_x, NEUT);
      chk("arst_valid", mem_valid, 0);
      chk("arst_full", full, 0);
      tick();
      rst = 1'b0;

      // Stop recording on the write cycle: nothing stored.
      press(1, 0, 0);
      tick(); tick();
      press(1, 0, 0);
      chk("stop_on_wr_state", state, 0);
      chk("stop_on_wr_count", count, 0);

      // Randomized run against the reference model.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 3000; i++) begin
         bit r, p, c, e, l;
         logic [7:0] ax, ay, az;
         r = ($urandom_range(0, 15) == 0);
         p = ($urandom_range(0, 15) == 0);
         c = ($urandom_range(0, 40) == 0);
         e = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 63) == 0) loop = ~loop;
         l = loop;
         ax = 8'($urandom_range(0, 255));
         ay = 8'($urandom_range(0, 255));
         az = 8'($urandom_range(0, 255));
         btn_rec = r; btn_play = p; btn_clear = c; enable = e;
         accel_x = ax; accel_y = ay; accel_z = az;
         tick();
         btn_rec = 1'b0; btn_play = 1'b0; btn_clear = 1'b0;
         model_step(r, p, c, e, l, ax, ay, az);
         chk("rnd_state", state, m_state);
         chk("rnd_count", count, px.size());
         chk("rnd_full", full, (px.size() == DEPTH) ? 1 : 0);
         chk("rnd_valid", mem_valid, m_valid);
         chk("rnd_mem_x", mem_x, m_ox);
         chk("rnd_mem_y", mem_y, m_oy);
         chk("rnd_mem_z", mem_z, m_oz);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
